slot_game_ctrl: RTL and testbench
=================================

SLOT_GAME_CTRL -- requirements
Module: slot_game_ctrl

Interface
REQ-001 Parameter N_REELS, default 3, number of reels (2..8).
REQ-002 Parameter SYM_W, default 3, symbol code width.
REQ-003 Parameter CREDIT_W, default 7, credit register width.
REQ-004 Parameter CREDIT_MAX, default 99, credit ceiling (at most 99 and at most 2^CREDIT_W-1).
REQ-005 Parameter BET, default 1, credits deducted per game.
REQ-006 Parameter AUTO_STOP, default 50_000_000, idle cycles before a reel auto-stops.
REQ-007 Reset RST, asynchronous, active-low; clock clk.
REQ-008 clk  in  1  system clock.
REQ-009 RST  in  1  async active-low reset.
REQ-010 coin_in  in  1  one-cycle coin pulse.
REQ-011 start  in  1  one-cycle game-start pulse.
REQ-012 stop  in  1  one-cycle reel-stop pulse.
REQ-013 cash_out  in  1  one-cycle cash-out request.
REQ-014 reel_sym  in  N_REELS*SYM_W  live symbols from reel spinners; reel i is at [i*SYM_W +: SYM_W].
REQ-015 reel_run  out  N_REELS  spin enable per reel.
REQ-016 held_sym  out  N_REELS*SYM_W  latched stop symbols.
REQ-017 credit  out  CREDIT_W  current credit, binary.
REQ-018 credit_bcd  out  8  credit as tens:ones BCD.
REQ-019 state  out  3  FSM state code.
REQ-020 win  out  CREDIT_W  last payout amount.
REQ-021 payout_valid  out  1  one-cycle pulse, win updated.
REQ-022 coin_rej  out  1  one-cycle pulse, coin refused.
REQ-023 cash_amt  out  CREDIT_W  credit paid out; cash_valid  out  1  one-cycle pulse.

Function
REQ-024 States: IDLE=0, READY=1, SPIN=2, EVAL=3.
REQ-025 IDLE: a coin sets credit to 1 and moves to READY; start and stop are ignored.
REQ-026 READY: a coin increments credit; start with credit>=BET deducts BET, sets all reel_run, clears the auto-stop counter, and enters SPIN on the next cycle.
REQ-027 READY: start with credit<BET is ignored.
REQ-028 Coin and start in the same cycle: credit becomes credit+1-BET.
REQ-029 Coin at credit==CREDIT_MAX in any state: credit is unchanged and coin_rej pulses in the same cycle.
REQ-030 SPIN: coins are accepted (saturating per REQ-029); start and cash_out are ignored.
REQ-031 SPIN stop, or auto-stop counter reaching AUTO_STOP-1: the lowest-index running reel has its reel_sym captured into held_sym and its reel_run cleared in that cycle; the counter restarts.
REQ-032 Only one reel stops per cycle; a stop pulse coinciding with auto-stop counts once.
REQ-033 Last reel stopped: the FSM enters EVAL on the next cycle.
REQ-034 EVAL (one cycle) payout:
  - all held symbols equal to s: win = s+1;
  - otherwise, reel0 equals reel1: win = BET;
  - otherwise: win = 0.
REQ-035 EVAL: credit = min(credit+win, CREDIT_MAX); payout_valid pulses; a simultaneous coin is added before the saturation.
REQ-036 After EVAL: go to READY if credit>0, otherwise IDLE.
REQ-037 cash_out in READY: cash_amt = credit, cash_valid pulses, credit becomes 0, and the FSM goes to IDLE; cash_out is ignored in other states.
REQ-038 cash_out together with coin in READY: the coin is added first, then the cash-out is applied.
REQ-039 credit_bcd is combinational from credit.

Reset
REQ-040 RST low forces: state IDLE; credit, win, cash_amt, held_sym, reel_run and the auto-stop counter to 0; all pulse outputs to 0.
REQ-041 Reset mid-SPIN drops the bet with no refund; operation resumes on the first clk edge after RST rises.

Structure
REQ-042 Package slot_pkg holds the state encoding constants, the symbol type, and the parameter defaults.
REQ-043 One sub-module, credit_bcd_conv, converts binary to BCD; all other logic is flat in slot_game_ctrl.

Verification
REQ-044 Reset, then 3 coins and start, stop×3 with symbols 5,5,5 -> credit 3→2, then win=6, credit=8, state READY.
REQ-045 Credit 99, then coin -> coin_rej pulse, credit stays 99; EVAL with win=8 -> credit 99.
REQ-046 Credit 1, start, no stop, AUTO_STOP=4 -> reels stop at 4-cycle intervals; symbols 1,2,3 give win=0, credit 0, state IDLE.
REQ-047 Credit 4, coin+cash_out in the same cycle -> cash_amt=5, cash_valid pulse, credit 0, state IDLE.
REQ-048 RST asserted in SPIN after one reel stopped -> every output returns to its reset value in the same cycle.
REQ-049 Symbols 2,2,7 -> win=BET=1.

Source files
------------

// File: rtl/slot_pkg.sv
// -----------------------------------------------------------------------------
// slot_pkg
//   Shared definitions for the slot machine game controller.
//   - Default values for every slot_game_ctrl parameter.
//   - FSM state encoding (the code is also driven onto the 'state' port).
//   - Symbol type at the default symbol width.
// -----------------------------------------------------------------------------
package slot_pkg;

  localparam int N_REELS_DEF    = 3;
  localparam int SYM_W_DEF      = 3;
  localparam int CREDIT_W_DEF   = 7;
  localparam int CREDIT_MAX_DEF = 99;
  localparam int BET_DEF        = 1;
  localparam int AUTO_STOP_DEF  = 50_000_000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_SPIN  = 3'd2,
    ST_EVAL  = 3'd3
  } state_t;

  typedef logic [SYM_W_DEF-1:0] sym_t;

endpackage

// File: rtl/credit_bcd_conv.sv
// -----------------------------------------------------------------------------
// credit_bcd_conv
//   Combinational binary to two-digit BCD converter (double dabble).
//   The credit value never exceeds 99, so only tens and ones digits are kept.
//
//   Ports
//     bin  in   BIN_W  binary credit value (0..99)
//     bcd  out  8      {tens, ones} BCD digits
// -----------------------------------------------------------------------------
module credit_bcd_conv #(
  parameter int BIN_W = 7
) (
  input  logic [BIN_W-1:0] bin,
  output logic [7:0]       bcd
);

  logic [7:0] bcd_work;

  // Shift the binary value in MSB first, adding 3 to any digit >= 5 before
  // each shift. A hundreds digit cannot occur for values up to 99, so the
  // bit shifted out of the tens digit is always zero and is dropped.
  always_comb begin
    bcd_work = '0;
    for (int i = BIN_W - 1; i >= 0; i--) begin
      if (bcd_work[3:0] >= 4'd5) bcd_work[3:0] = bcd_work[3:0] + 4'd3;
      if (bcd_work[7:4] >= 4'd5) bcd_work[7:4] = bcd_work[7:4] + 4'd3;
      bcd_work = {bcd_work[6:0], bin[i]};
    end
  end

  assign bcd = bcd_work;

endmodule

// File: rtl/slot_game_ctrl.sv
// -----------------------------------------------------------------------------
// slot_game_ctrl
//   Credit, reel and payout controller for a simple slot machine.
//   IDLE -> (coin) READY -> (start) SPIN -> (last reel stopped) EVAL ->
//   READY or IDLE depending on the remaining credit.
//
//   Ports
//     clk           in   1               system clock
//     RST           in   1               asynchronous reset, active low
//     coin_in       in   1               one-cycle coin pulse
//     start         in   1               one-cycle game-start pulse
//     stop          in   1               one-cycle reel-stop pulse
//     cash_out      in   1               one-cycle cash-out request
//     reel_sym      in   N_REELS*SYM_W   live reel symbols, reel i at [i*SYM_W +: SYM_W]
//     reel_run      out  N_REELS         spin enable per reel
//     held_sym      out  N_REELS*SYM_W   symbols latched when each reel stopped
//     credit        out  CREDIT_W        current credit (binary)
//     credit_bcd    out  8               current credit as tens:ones BCD
//     state         out  3               FSM state code
//     win           out  CREDIT_W        last payout amount
//     payout_valid  out  1               one-cycle pulse, win updated
//     coin_rej      out  1               one-cycle pulse, coin refused (credit full)
//     cash_amt      out  CREDIT_W        amount paid out on cash-out
//     cash_valid    out  1               one-cycle pulse, cash_amt updated
//
//   CREDIT_MAX must be <= 99 and <= 2**CREDIT_W-1; CREDIT_W must exceed SYM_W
//   so the largest jackpot (max symbol + 1) fits in win.
// -----------------------------------------------------------------------------
module slot_game_ctrl
  import slot_pkg::*;
#(
  parameter int N_REELS    = N_REELS_DEF,
  parameter int SYM_W      = SYM_W_DEF,
  parameter int CREDIT_W   = CREDIT_W_DEF,
  parameter int CREDIT_MAX = CREDIT_MAX_DEF,
  parameter int BET        = BET_DEF,
  parameter int AUTO_STOP  = AUTO_STOP_DEF
) (
  input  logic                       clk,
  input  logic                       RST,
  input  logic                       coin_in,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       cash_out,
  input  logic [N_REELS*SYM_W-1:0]   reel_sym,
  output logic [N_REELS-1:0]         reel_run,
  output logic [N_REELS*SYM_W-1:0]   held_sym,
  output logic [CREDIT_W-1:0]        credit,
  output logic [7:0]                 credit_bcd,
  output logic [2:0]                 state,
  output logic [CREDIT_W-1:0]        win,
  output logic                       payout_valid,
  output logic                       coin_rej,
  output logic [CREDIT_W-1:0]        cash_amt,
  output logic                       cash_valid
);

  localparam int CNT_W = (AUTO_STOP > 1) ? $clog2(AUTO_STOP) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(AUTO_STOP - 1);
  localparam logic [CREDIT_W-1:0] CMAX     = CREDIT_W'(CREDIT_MAX);
  localparam logic [CREDIT_W-1:0] BET_V    = CREDIT_W'(BET);

  state_t fsm_state, state_nxt;

  logic [CREDIT_W-1:0]      credit_q, credit_nxt;
  logic [CREDIT_W-1:0]      win_q, win_nxt;
  logic [CREDIT_W-1:0]      cash_amt_q, cash_amt_nxt;
  logic [N_REELS*SYM_W-1:0] held_q, held_nxt;
  logic [N_REELS-1:0]       run_q, run_nxt;
  logic [CNT_W-1:0]         cnt_q, cnt_nxt;
  logic                     payout_valid_q, payout_valid_nxt;
  logic                     cash_valid_q, cash_valid_nxt;

  logic                     coin_ok;
  logic [CREDIT_W-1:0]      credit_coin;
  logic [N_REELS-1:0]       lowest_run;
  logic                     last_reel;
  logic                     all_eq;
  logic [CREDIT_W-1:0]      win_calc;
  logic [CREDIT_W:0]        eval_sum;
  logic [CREDIT_W-1:0]      eval_credit;

  // A coin is only taken while the credit is below the ceiling; credit_coin
  // is the credit with that coin folded in and cannot overflow.
  assign coin_ok     = coin_in && (credit_q < CMAX);
  assign coin_rej    = coin_in && (credit_q == CMAX);
  assign credit_coin = credit_q + CREDIT_W'(coin_ok);

  // Isolate the lowest set bit of the run mask: the next reel to stop.
  // When it is the only bit left, this stop finishes the spin.
  assign lowest_run = run_q & (~run_q + N_REELS'(1));
  assign last_reel  = (run_q == lowest_run);

  // Payout from the held symbols: jackpot of symbol+1 when every reel
  // matches, the bet back when only the first two match.
  always_comb begin
    all_eq = 1'b1;
    for (int i = 1; i < N_REELS; i++) begin
      if (held_q[i*SYM_W +: SYM_W] != held_q[SYM_W-1:0]) all_eq = 1'b0;
    end
  end

  always_comb begin
    win_calc = '0;
    if (all_eq)
      win_calc = CREDIT_W'(held_q[SYM_W-1:0]) + CREDIT_W'(1);
    else if (held_q[SYM_W +: SYM_W] == held_q[SYM_W-1:0])
      win_calc = BET_V;
  end

  // One extra bit keeps credit + coin + win exact before saturating.
  assign eval_sum    = {1'b0, credit_coin} + {1'b0, win_calc};
  assign eval_credit = (eval_sum > {1'b0, CMAX}) ? CMAX : eval_sum[CREDIT_W-1:0];

  // Next-state and datapath next values. In READY a start with enough credit
  // takes priority over a simultaneous cash-out.
  always_comb begin
    state_nxt        = fsm_state;
    credit_nxt       = credit_q;
    win_nxt          = win_q;
    cash_amt_nxt     = cash_amt_q;
    held_nxt         = held_q;
    run_nxt          = run_q;
    cnt_nxt          = cnt_q;
    payout_valid_nxt = 1'b0;
    cash_valid_nxt   = 1'b0;

    case (fsm_state)
      ST_IDLE: begin
        if (coin_ok) begin
          credit_nxt = CREDIT_W'(1);
          state_nxt  = ST_READY;
        end
      end

      ST_READY: begin
        credit_nxt = credit_coin;
        if (start && (credit_q >= BET_V)) begin
          credit_nxt = credit_coin - BET_V;
          run_nxt    = '1;
          cnt_nxt    = '0;
          state_nxt  = ST_SPIN;
        end else if (cash_out) begin
          cash_amt_nxt   = credit_coin;
          cash_valid_nxt = 1'b1;
          credit_nxt     = '0;
          state_nxt      = ST_IDLE;
        end
      end

      ST_SPIN: begin
        credit_nxt = credit_coin;
        if (stop || (cnt_q == CNT_LAST)) begin
          for (int i = 0; i < N_REELS; i++) begin
            if (lowest_run[i]) held_nxt[i*SYM_W +: SYM_W] = reel_sym[i*SYM_W +: SYM_W];
          end
          run_nxt = run_q & ~lowest_run;
          cnt_nxt = '0;
          if (last_reel) state_nxt = ST_EVAL;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end

      ST_EVAL: begin
        credit_nxt       = eval_credit;
        win_nxt          = win_calc;
        payout_valid_nxt = 1'b1;
        state_nxt        = (eval_credit != '0) ? ST_READY : ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) fsm_state <= ST_IDLE;
    else      fsm_state <= state_nxt;
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      credit_q       <= '0;
      win_q          <= '0;
      cash_amt_q     <= '0;
      held_q         <= '0;
      run_q          <= '0;
      cnt_q          <= '0;
      payout_valid_q <= 1'b0;
      cash_valid_q   <= 1'b0;
    end else begin
      credit_q       <= credit_nxt;
      win_q          <= win_nxt;
      cash_amt_q     <= cash_amt_nxt;
      held_q         <= held_nxt;
      run_q          <= run_nxt;
      cnt_q          <= cnt_nxt;
      payout_valid_q <= payout_valid_nxt;
      cash_valid_q   <= cash_valid_nxt;
    end
  end

  credit_bcd_conv #(
    .BIN_W (CREDIT_W)
  ) u_bcd (
    .bin (credit_q),
    .bcd (credit_bcd)
  );

  assign state        = fsm_state;
  assign credit       = credit_q;
  assign win          = win_q;
  assign cash_amt     = cash_amt_q;
  assign held_sym     = held_q;
  assign reel_run     = run_q;
  assign payout_valid = payout_valid_q;
  assign cash_valid   = cash_valid_q;

endmodule

// File: tb/tb_slot_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_slot_game_ctrl
//   Directed self-checking bench for slot_game_ctrl with AUTO_STOP = 4.
// -----------------------------------------------------------------------------
module tb_slot_game_ctrl;

  localparam int N_REELS = 3;
  localparam int SYM_W   = 3;
  localparam int CW      = 7;

  logic                     clk = 1'b0;
  logic                     RST;
  logic                     coin_in, start, stop, cash_out;
  logic [N_REELS*SYM_W-1:0] reel_sym;
  logic [N_REELS-1:0]       reel_run;
  logic [N_REELS*SYM_W-1:0] held_sym;
  logic [CW-1:0]            credit;
  logic [7:0]               credit_bcd;
  logic [2:0]               state;
  logic [CW-1:0]            win;
  logic                     payout_valid;
  logic                     coin_rej;
  logic [CW-1:0]            cash_amt;
  logic                     cash_valid;

  int n_checks = 0;
  int n_pass   = 0;

  slot_game_ctrl #(
    .N_REELS    (N_REELS),
    .SYM_W      (SYM_W),
    .CREDIT_W   (CW),
    .CREDIT_MAX (99),
    .BET        (1),
    .AUTO_STOP  (4)
  ) dut (
    .clk          (clk),
    .RST          (RST),
    .coin_in      (coin_in),
    .start        (start),
    .stop         (stop),
    .cash_out     (cash_out),
    .reel_sym     (reel_sym),
    .reel_run     (reel_run),
    .held_sym     (held_sym),
    .credit       (credit),
    .credit_bcd   (credit_bcd),
    .state        (state),
    .win          (win),
    .payout_valid (payout_valid),
    .coin_rej     (coin_rej),
    .cash_amt     (cash_amt),
    .cash_valid   (cash_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Drive one cycle of pulses starting just after a rising edge, then land
  // 1 time unit after the next rising edge with all pulses cleared.
  task automatic applyStimulus(input logic c, input logic s, input logic p, input logic o);
    coin_in  = c;
    start    = s;
    stop     = p;
    cash_out = o;
    @(posedge clk);
    #1;
    coin_in  = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    cash_out = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " state"},        32'(state),        32'd0);
    checkOutput({tag, " credit"},       32'(credit),       32'd0);
    checkOutput({tag, " credit_bcd"},   32'(credit_bcd),   32'd0);
    checkOutput({tag, " reel_run"},     32'(reel_run),     32'd0);
    checkOutput({tag, " held_sym"},     32'(held_sym),     32'd0);
    checkOutput({tag, " win"},          32'(win),          32'd0);
    checkOutput({tag, " cash_amt"},     32'(cash_amt),     32'd0);
    checkOutput({tag, " payout_valid"}, 32'(payout_valid), 32'd0);
    checkOutput({tag, " cash_valid"},   32'(cash_valid),   32'd0);
    checkOutput({tag, " coin_rej"},     32'(coin_rej),     32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N_REELS*SYM_W-1:0] exp_held;

    RST      = 1'b0;
    coin_in  = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    cash_out = 1'b0;
    reel_sym = '0;

    // Reset values
    waitCycles(2);
    checkResetOutputs("reset");
    RST = 1'b1;

    // Start and stop ignored in IDLE
    applyStimulus(0, 1, 0, 0);
    checkOutput("idle start ignored", 32'(state), 32'd0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("idle stop ignored run", 32'(reel_run), 32'd0);

    // Three coins, start, 5-5-5 jackpot
    applyStimulus(1, 0, 0, 0);
    checkOutput("first coin state", 32'(state), 32'd1);
    checkOutput("first coin credit", 32'(credit), 32'd1);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("three coins credit", 32'(credit), 32'd3);
    checkOutput("three coins bcd", 32'(credit_bcd), 32'h03);
    reel_sym = {3'd5, 3'd5, 3'd5};
    applyStimulus(0, 1, 0, 0);
    checkOutput("start credit", 32'(credit), 32'd2);
    checkOutput("start state", 32'(state), 32'd2);
    checkOutput("start reel_run", 32'(reel_run), 32'b111);
    applyStimulus(0, 0, 1, 0);
    checkOutput("stop1 reel_run", 32'(reel_run), 32'b110);
    checkOutput("stop1 held reel0", 32'(held_sym[2:0]), 32'd5);
    applyStimulus(0, 0, 1, 0);
    checkOutput("stop2 reel_run", 32'(reel_run), 32'b100);
    applyStimulus(0, 0, 1, 0);
    checkOutput("stop3 reel_run", 32'(reel_run), 32'b000);
    checkOutput("stop3 state eval", 32'(state), 32'd3);
    checkOutput("eval no payout yet", 32'(payout_valid), 32'd0);
    waitCycles(1);
    checkOutput("jackpot win", 32'(win), 32'd6);
    checkOutput("jackpot credit", 32'(credit), 32'd8);
    checkOutput("jackpot payout_valid", 32'(payout_valid), 32'd1);
    checkOutput("jackpot state", 32'(state), 32'd1);
    checkOutput("jackpot bcd", 32'(credit_bcd), 32'h08);
    waitCycles(1);
    checkOutput("payout_valid drops", 32'(payout_valid), 32'd0);

    // Symbols 2,2,7: first two match, win = BET
    reel_sym = {3'd7, 3'd2, 3'd2};
    exp_held = {3'd7, 3'd2, 3'd2};
    applyStimulus(0, 1, 0, 0);
    checkOutput("pair start credit", 32'(credit), 32'd7);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("pair held_sym", 32'(held_sym), 32'(exp_held));
    waitCycles(1);
    checkOutput("pair win", 32'(win), 32'd1);
    checkOutput("pair credit", 32'(credit), 32'd8);

    // Plain cash-out of 8
    applyStimulus(0, 0, 0, 1);
    checkOutput("cash8 amt", 32'(cash_amt), 32'd8);
    checkOutput("cash8 valid", 32'(cash_valid), 32'd1);
    checkOutput("cash8 credit", 32'(credit), 32'd0);
    checkOutput("cash8 state", 32'(state), 32'd0);
    waitCycles(1);
    checkOutput("cash_valid drops", 32'(cash_valid), 32'd0);

    // Credit 4, coin together with cash-out
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0);
    checkOutput("four coins credit", 32'(credit), 32'd4);
    applyStimulus(1, 0, 0, 1);
    checkOutput("coin+cash amt", 32'(cash_amt), 32'd5);
    checkOutput("coin+cash valid", 32'(cash_valid), 32'd1);
    checkOutput("coin+cash credit", 32'(credit), 32'd0);
    checkOutput("coin+cash state", 32'(state), 32'd0);

    // Credit 1, start, auto-stop every 4 cycles, symbols 1,2,3 lose
    applyStimulus(1, 0, 0, 0);
    reel_sym = {3'd3, 3'd2, 3'd1};
    applyStimulus(0, 1, 0, 0);
    checkOutput("auto start credit", 32'(credit), 32'd0);
    waitCycles(3);
    checkOutput("auto before 1st stop", 32'(reel_run), 32'b111);
    waitCycles(1);
    checkOutput("auto 1st stop", 32'(reel_run), 32'b110);
    checkOutput("auto held reel0", 32'(held_sym[2:0]), 32'd1);
    waitCycles(3);
    checkOutput("auto before 2nd stop", 32'(reel_run), 32'b110);
    waitCycles(1);
    checkOutput("auto 2nd stop", 32'(reel_run), 32'b100);
    waitCycles(4);
    checkOutput("auto 3rd stop", 32'(reel_run), 32'b000);
    checkOutput("auto eval state", 32'(state), 32'd3);
    waitCycles(1);
    checkOutput("lose win", 32'(win), 32'd0);
    checkOutput("lose credit", 32'(credit), 32'd0);
    checkOutput("lose payout_valid", 32'(payout_valid), 32'd1);
    checkOutput("lose state idle", 32'(state), 32'd0);

    // Fill to 99, coin refused, saturating payout
    for (int i = 0; i < 99; i++) applyStimulus(1, 0, 0, 0);
    checkOutput("fill credit", 32'(credit), 32'd99);
    checkOutput("fill bcd", 32'(credit_bcd), 32'h99);
    coin_in = 1'b1;
    #1;
    checkOutput("full coin_rej", 32'(coin_rej), 32'd1);
    @(posedge clk);
    #1;
    coin_in = 1'b0;
    #1;
    checkOutput("full credit kept", 32'(credit), 32'd99);
    checkOutput("coin_rej drops", 32'(coin_rej), 32'd0);
    reel_sym = {3'd7, 3'd7, 3'd7};
    applyStimulus(0, 1, 0, 0);
    checkOutput("sat start credit", 32'(credit), 32'd98);
    applyStimulus(1, 0, 1, 0);
    checkOutput("spin coin credit", 32'(credit), 32'd99);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    waitCycles(1);
    checkOutput("sat win", 32'(win), 32'd8);
    checkOutput("sat credit", 32'(credit), 32'd99);
    checkOutput("sat state", 32'(state), 32'd1);

    // Reset in SPIN after one reel stopped
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("pre-reset reel_run", 32'(reel_run), 32'b110);
    #2;
    RST = 1'b0;
    #1;
    checkResetOutputs("mid-spin reset");
    RST = 1'b1;
    waitCycles(1);

    // Resume; coin and start together; cash-out ignored in SPIN
    applyStimulus(1, 0, 0, 0);
    checkOutput("resume credit", 32'(credit), 32'd1);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("coin+start credit", 32'(credit), 32'd2);
    checkOutput("coin+start state", 32'(state), 32'd2);
    applyStimulus(0, 0, 0, 1);
    checkOutput("spin cash ignored state", 32'(state), 32'd2);
    checkOutput("spin cash ignored valid", 32'(cash_valid), 32'd0);
    checkOutput("spin cash ignored credit", 32'(credit), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
